// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file widths, arbiter defaults and the pending-mask helper
// used by the write-back arbiter.
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_LEN     = 5;
    localparam int REG_LEN          = 32;
    localparam int DEPTH_DEF        = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    // x0 is hardwired, so it never counts as a pending destination.
    function automatic logic [31:0] reg_onehot(input logic [31:0] addr);
        if (addr == 32'd0 || addr > 32'd31) return 32'd0;
        return 32'd1 << addr[4:0];
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// Long-latency result buffer: DEPTH entries of {addr, data}, with per-slot
// valid bits and addresses exposed for pending-write tracking.
module reg_wb_arbiter_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int AW    = 5,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic [CW-1:0]             count,
    output logic [DEPTH-1:0]          entry_vld,
    output logic [DEPTH-1:0][AW-1:0]  entry_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_addr[i] = mem[i][W-1 -: AW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                entry_vld[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                entry_vld[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline has priority, buffered
// long-latency results are force-granted after STARVE_LIMIT lost cycles.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = REG_ADDR_LEN,
    parameter int DW           = REG_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           p_valid,
    input  logic [AW-1:0]  p_addr,
    input  logic [DW-1:0]  p_data,
    output logic           p_ready,
    input  logic           l_valid,
    input  logic [AW-1:0]  l_addr,
    input  logic [DW-1:0]  l_data,
    output logic           l_ready,
    output logic           write_enable,
    output logic [AW-1:0]  write_addr,
    output logic [DW-1:0]  write_data,
    output logic [31:0]    pend_mask
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [AW+DW-1:0]         head;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         entry_vld;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [SW-1:0]            starve_cnt;
    logic                     fifo_nonempty;
    logic                     force_grant;
    logic                     p_grant;
    logic                     f_grant;
    logic                     push;

    assign head_addr     = head[AW+DW-1:DW];
    assign head_data     = head[DW-1:0];
    assign fifo_nonempty = (count != '0);
    assign force_grant   = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;
    assign p_ready       = !force_grant;
    assign p_grant       = p_valid && !force_grant;
    assign f_grant       = fifo_nonempty && !p_grant;
    // Full is judged on the registered count, so a pop never frees a slot for the same cycle.
    assign l_ready       = (count < CW'(DEPTH));
    assign push          = l_valid && l_ready;

    reg_wb_arbiter_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW),
        .AW    (AW),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ({l_addr, l_data}),
        .pop        (f_grant),
        .head       (head),
        .count      (count),
        .entry_vld  (entry_vld),
        .entry_addr (entry_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt   <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            if (!fifo_nonempty || f_grant) begin
                starve_cnt <= '0;
            end else if (p_grant && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (p_grant) begin
                write_enable <= (p_addr != '0);
                write_addr   <= p_addr;
                write_data   <= p_data;
            end else if (f_grant) begin
                write_enable <= (head_addr != '0);
                write_addr   <= head_addr;
                write_data   <= head_data;
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pend_mask = pend_mask | reg_onehot(32'(entry_addr[i]));
        end
        if (write_enable) pend_mask = pend_mask | reg_onehot(32'(write_addr));
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: hand-computed vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_reg_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int AW           = 5;
    localparam int DW           = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p_valid = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          p_ready;
    logic          l_valid = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_data = '0;
    logic          l_ready;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [31:0]   pend_mask;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p_valid      (p_valid),
        .p_addr       (p_addr),
        .p_data       (p_data),
        .p_ready      (p_ready),
        .l_valid      (l_valid),
        .l_addr       (l_addr),
        .l_data       (l_data),
        .l_ready      (l_ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pend_mask    (pend_mask)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents as queues, lost-cycle counter, output stage.
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          m_starve = 0;
    bit          m_we = 1'b0;
    logic [31:0] m_wa = '0;
    logic [31:0] m_wd = '0;

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_pr;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input logic [31:0] a);
        if (a == 0 || a > 31) return 32'd0;
        return 32'd1 << a[4:0];
    endfunction

    function automatic bit m_force();
        return (m_starve == STARVE_LIMIT) && (q_addr.size() != 0);
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] r;
        r = m_we ? onehot(m_wa) : 32'd0;
        foreach (q_addr[i]) r = r | onehot(q_addr[i]);
        return r;
    endfunction

    task automatic set_in(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                          input logic lv, input logic [4:0] la, input logic [31:0] ld);
        p_valid = pv;
        p_addr  = pa;
        p_data  = pd;
        l_valid = lv;
        l_addr  = la;
        l_data  = ld;
    endtask

    task automatic check_model();
        chk("p_ready", 32'(p_ready), 32'(!m_force()));
        chk("l_ready", 32'(l_ready), 32'(q_addr.size() < DEPTH));
        chk("write_enable", 32'(write_enable), 32'(m_we));
        if (m_we) begin
            chk("write_addr", 32'(write_addr), m_wa);
            chk("write_data", write_data, m_wd);
        end
        chk("pend_mask", pend_mask, m_pend());
    endtask

    // Advance the model by one clock using the inputs now driven, then clock the DUT.
    task automatic step();
        bit ne, f, lr, pg, fg;
        ne = (q_addr.size() != 0);
        f  = m_force();
        lr = (q_addr.size() < DEPTH);
        pg = p_valid && !f;
        fg = ne && !pg;
        if (!ne || fg) m_starve = 0;
        else if (pg && m_starve < STARVE_LIMIT) m_starve++;
        if (pg) begin
            m_we = (p_addr != 0);
            m_wa = 32'(p_addr);
            m_wd = p_data;
        end else if (fg) begin
            m_we = (q_addr[0] != 0);
            m_wa = q_addr[0];
            m_wd = q_data[0];
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end else begin
            m_we = 1'b0;
        end
        if (l_valid && lr) begin
            q_addr.push_back(32'(l_addr));
            q_data.push_back(l_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        set_in(pv, pa, pd, lv, la, ld);
        #4;
        check_model();
        step();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear immediately, release lands on a negedge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_write_enable", 32'(write_enable), 32'd0);
        chk("rst_write_addr", 32'(write_addr), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_pend_mask", pend_mask, 32'd0);
        q_addr.delete();
        q_data.delete();
        m_starve = 0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        @(negedge clk);
        rst = 1'b1;
        check_model();
        step();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h80};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'h88};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'h80};
        tbl[4]  = '{1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[6]  = '{1'b1, 5'd1, 32'h1,    1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[7]  = '{1'b1, 5'd2, 32'h2,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd1, 32'h202};
        tbl[8]  = '{1'b1, 5'd3, 32'h3,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd2, 32'h204};
        tbl[9]  = '{1'b1, 5'd4, 32'h4,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'h208};
        tbl[10] = '{1'b1, 5'd5, 32'h5,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd4, 32'h210};
        tbl[11] = '{1'b1, 5'd6, 32'h6,    1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd5, 32'h220};
        tbl[12] = '{1'b1, 5'd6, 32'h6,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd9, 32'h200};
        tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd6, 32'h40};

        // Reset with l_valid held; first push must reach write_* two cycles after release.
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
        #1;
        do_reset();
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("first_push_addr", 32'(write_addr), 32'd5);
        chk("first_push_data", write_data, 32'h11);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Priority, x0 suppression and starvation force-grant, with hand-derived values.
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld);
            #4;
            check_model();
            chk($sformatf("tbl%0d_p_ready", i), 32'(p_ready), 32'(tbl[i].e_pr));
            chk($sformatf("tbl%0d_l_ready", i), 32'(l_ready), 32'(tbl[i].e_lr));
            chk($sformatf("tbl%0d_write_enable", i), 32'(write_enable), 32'(tbl[i].e_we));
            if (tbl[i].e_we) chk($sformatf("tbl%0d_write_addr", i), 32'(write_addr), 32'(tbl[i].e_wa));
            chk($sformatf("tbl%0d_pend_mask", i), pend_mask, tbl[i].e_pend);
            step();
        end

        // Fill the FIFO behind a busy pipeline; the third long-latency offer is refused.
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB1);
        cycle(1'b1, 5'd12, 32'hA1, 1'b1, 5'd13, 32'hB2);
        set_in(1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hB3);
        #4;
        chk("full_l_ready", 32'(l_ready), 32'd0);
        check_model();
        step();
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'(16 + i), 32'hC0 + 32'(i), 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset while two entries are buffered: nothing stale may ever be written.
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hE0);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'hE1);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            logic [4:0] pa, la;
            pa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            la = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 99) == 0) begin
                set_in(1'($urandom_range(0, 1)), pa, $urandom, 1'($urandom_range(0, 1)), la, $urandom);
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 2) != 0), pa, $urandom, 1'($urandom_range(0, 1)), la, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the register file's single write port between two write-back sources:
- the in-order pipeline write-back stage;
- the long-latency unit (load/multi-cycle ALU) return path.
Long-latency results are buffered in a small FIFO. The pipeline has priority, and a starvation limit bounds how long the FIFO can wait. The block drives write_enable/write_addr/write_data of the register file. It also exports a pending-write mask to issue-stage hazard logic.

Parameters:
DEPTH, 2, long-latency FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose before it is force-granted
AW, 5, register address width (`RegAddrlen)
DW, 32, register data width (`Reglen)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
p_valid  in  1  pipeline write-back request
p_addr  in  AW  pipeline destination register
p_data  in  DW  pipeline result
p_ready  out  1  pipeline request accepted this cycle (combinational)
l_valid  in  1  long-latency result valid
l_addr  in  AW  long-latency destination register
l_data  in  DW  long-latency result
l_ready  out  1  FIFO can accept (registered-count based)
write_enable  out  1  register file write enable (registered)
write_addr  out  AW  register file write address (registered)
write_data  out  DW  register file write data (registered)
pend_mask  out  32  bit r set while a write to r sits in the FIFO or output stage

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; starve_cnt=0.
  - write_enable=0, write_addr=0, write_data=0.
  - pend_mask=0; l_ready=1 after reset release.
- Latency: a request granted in cycle N appears on write_* in cycle N+1, for exactly one cycle.
- Handshakes:
  - Pipeline transfer when p_valid&p_ready.
  - Long-latency push when l_valid&l_ready.
  - l_ready = (count < DEPTH), computed from the registered count. There is no same-cycle pop-then-push when full.
- Arbitration, each cycle:
  - force = (starve_cnt == STARVE_LIMIT) & fifo_nonempty.
  - If force: FIFO head granted, p_ready=0.
  - Else if p_valid: pipeline granted, p_ready=1.
  - Else if fifo_nonempty: FIFO head granted.
  - Else nothing is granted and write_enable=0 next cycle.
- p_ready=1 whenever not forcing, including when p_valid=0.
- Starvation counter:
  - Increments when FIFO is nonempty and the pipeline is granted; saturates at STARVE_LIMIT.
  - Clears on FIFO grant or when FIFO is empty.
- Push and pop in the same cycle (not full): count unchanged, pointers both advance modulo DEPTH.
- x0 (addr 0): granted and dequeued normally, but write_enable=0 on output. Addr 0 never sets pend_mask.
- pend_mask:
  - OR of one-hot addresses of valid FIFO entries, plus the output stage when write_enable=1.
  - Updated from registered state only; the mask is combinational from registers.
- Ordering: per-source order is preserved. Cross-source WAW ordering is guaranteed upstream via pend_mask; the block does not check it.
- Reset mid-operation: all buffered results are discarded. No write is issued after reset asserts.

Decomposition:
- Shared config include: AW/DW (`RegAddrlen, `Reglen), `WriteEnable, `ZeroReg, `ZeroWord. No new typedefs.
- One sub-module: wb_fifo (DEPTH x (AW+DW)).
  - Ports: push, pop, head, count, entry-valid vector.
  - The vector is for pend_mask generation.
- Arbitration and starvation logic stay in the top module.

Test Plan:
1. Reset with l_valid=1 held; release rst -> write_enable=0, pend_mask=0, l_ready=1. First push of (x5, 0x11) appears as write_addr=5, write_data=0x11 two cycles after release.
2. p_valid=1 (x3, 0xAAAA) and FIFO holding (x7, 0x77) in the same cycle -> cycle N+1: write x3=0xAAAA; cycle N+2 (p_valid=0): write x7=0x77. pend_mask bit7 clears after N+2.
3. p_valid held 1 continuously, one FIFO entry (x9) -> pipeline wins 4 cycles. Cycle 5: p_ready=0 and x9 written the next cycle. starve_cnt returns to 0.
4. Fill FIFO (DEPTH=2) with p_valid=1 blocking pops -> l_ready=0 after the second push. Third l_valid is not accepted. After the forced pop, l_ready=1.
5. Pipeline write to x0 (0xDEAD) -> p_ready=1, write_enable=0 next cycle, pend_mask unchanged.
6. Assert rst for 1 cycle while FIFO holds 2 entries -> write_enable=0, pend_mask=0 immediately. No stale write ever appears.
